// File: rtl/rpi_if_pkg.sv
// Shared types and constants for the Raspberry Pi sample/IRQ handoff block.
package rpi_if_pkg;

  // Handshake FSM states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefDepth = 8;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  // Saturating add for the drop counter
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return (sum > {1'b0, DROP_MAX}) ? DROP_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/rpi_sample_fifo.sv
// Synchronous sample FIFO. Pointers carry one extra wrap bit so full and empty
// can be told apart. A write on a full FIFO is accepted when a pop happens in
// the same cycle, since the pop frees the slot.
module rpi_sample_fifo
  import rpi_if_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push;
  logic              pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign pop     = rd & ~empty;
  assign push    = wr & (~full | pop);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; contents are abandoned on reset by clearing the pointers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rpi_sample_irq_handoff.sv
// Presents buffered audio samples to a Raspberry Pi on each enabled rising
// edge of the divided interrupt clock, using a 4-phase irq/ack handshake.
// Optional feature: define RPI_IRQ_TIMEOUT_EN to abandon a presentation when
// the Pi does not acknowledge within TIMEOUT cycles.
module rpi_sample_irq_handoff
  import rpi_if_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth
`ifdef RPI_IRQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 256
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   irq_clk,
  input  logic                   interrupt_enable,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_data,
  input  logic                   rpi_ack,
  output logic                   rpi_irq,
  output logic [DATA_W-1:0]      rpi_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  logic              ack_meta_q;
  logic              ack_s_q;
  logic              irq_clk_q;
  logic              irq_edge;
  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] rpi_data_q;
  logic              full;
  logic              empty;
  logic              launch;
  logic              drop;
  logic              timeout;
  logic              overflow_q;
  logic [7:0]        drop_count_q;

  rpi_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr      (sample_valid),
    .wr_data (sample_data),
    .rd      (launch),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Two-flop synchronizer for the Pi ack and edge register for irq_clk
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      irq_clk_q  <= 1'b0;
    end else begin
      ack_meta_q <= rpi_ack;
      ack_s_q    <= ack_meta_q;
      irq_clk_q  <= irq_clk;
    end
  end

  assign irq_edge = irq_clk & ~irq_clk_q;
  // Edges that arrive while empty, disabled or busy are simply lost
  assign launch   = (state_q == StIdle) & irq_edge & interrupt_enable & ~empty;
  // A pop in the same cycle frees a slot, so only an unpaired full write drops
  assign drop     = sample_valid & full & ~launch;

`ifdef RPI_IRQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign timeout = (state_q == StPresent) & ~ack_s_q & (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Cycles spent in PRESENT; held at zero elsewhere so every entry starts fresh
  always_ff @(posedge clk_in) begin
    if (!rst_n || state_q != StPresent) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (launch) state_d = StPresent;
      end
      StPresent: begin
        if (ack_s_q) begin
          state_d = StRelease;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StRelease: begin
        if (!ack_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // irq falls in the same cycle the synchronized ack is seen
  assign rpi_irq = (state_q == StPresent) & ~ack_s_q;

  // Presented sample, sticky overflow and saturating drop counter
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rpi_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (launch) rpi_data_q <= head;
      if (drop || timeout) overflow_q <= 1'b1;
      drop_count_q <= sat_add(drop_count_q, {1'b0, drop} + {1'b0, timeout});
    end
  end

  assign rpi_data   = rpi_data_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rpi_sample_irq_handoff.sv
// Directed bench for rpi_sample_irq_handoff (DATA_W=16, DEPTH=8).
module tb_rpi_sample_irq_handoff;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_clk = 1'b0;
  logic        interrupt_enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        rpi_ack = 1'b0;
  logic        rpi_irq;
  logic [15:0] rpi_data;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #10 clk_in = ~clk_in;

  rpi_sample_irq_handoff #(
    .DATA_W (16),
    .DEPTH  (8)
  ) dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .irq_clk          (irq_clk),
    .interrupt_enable (interrupt_enable),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .rpi_ack          (rpi_ack),
    .rpi_irq          (rpi_irq),
    .rpi_data         (rpi_data),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_sample(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick(1);
    sample_valid = 1'b0;
  endtask

  // Raise irq_clk for one cycle and expect a launch of the given head sample
  task automatic launch_expect(input string tag, input logic [15:0] d, input logic [3:0] lvl);
    irq_clk = 1'b1;
    check({tag, " irq before edge"}, rpi_irq, 1'b0);
    tick(1);
    irq_clk = 1'b0;
    check({tag, " irq one cycle after edge"}, rpi_irq, 1'b1);
    check({tag, " data"}, rpi_data, d);
    check({tag, " level"}, fifo_level, lvl);
  endtask

  // Pi model: ack 10 cycles after irq, release 10 cycles after irq falls
  task automatic handshake(input string tag);
    tick(10);
    rpi_ack = 1'b1;
    tick(1);
    check({tag, " irq held during ack sync"}, rpi_irq, 1'b1);
    tick(1);
    check({tag, " irq drops two cycles after ack"}, rpi_irq, 1'b0);
    tick(10);
    rpi_ack = 1'b0;
    tick(1);
    check({tag, " irq low in release"}, rpi_irq, 1'b0);
    tick(2);
  endtask

  // Edge that must not produce an interrupt
  task automatic quiet_edge(input string tag);
    irq_clk = 1'b1;
    tick(1);
    irq_clk = 1'b0;
    check({tag, " no irq"}, rpi_irq, 1'b0);
    tick(2);
    check({tag, " still no irq"}, rpi_irq, 1'b0);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst irq", rpi_irq, 1'b0);
    check("rst data", rpi_data, 16'h0);
    check("rst level", fifo_level, 4'd0);
    check("rst overflow", overflow, 1'b0);
    check("rst drop_count", drop_count, 8'd0);
    rst_n = 1'b1;
    tick(1);

    // Three samples delivered in order
    interrupt_enable = 1'b1;
    write_sample(16'h1111);
    write_sample(16'h2222);
    write_sample(16'h3333);
    check("fill3 level", fifo_level, 4'd3);
    tick(2);
    launch_expect("s1", 16'h1111, 4'd2);
    handshake("s1");
    launch_expect("s2", 16'h2222, 4'd1);
    handshake("s2");
    launch_expect("s3", 16'h3333, 4'd0);
    handshake("s3");
    check("data held after transfer", rpi_data, 16'h3333);

    // Empty FIFO ignores edges; a late write fires on the next edge
    quiet_edge("empty");
    write_sample(16'h4444);
    tick(4);
    launch_expect("late", 16'h4444, 4'd0);
    handshake("late");

    // Overfill with interrupts disabled
    interrupt_enable = 1'b0;
    for (int i = 0; i < 10; i++) write_sample(16'hA000 + 16'(i));
    check("ovf level", fifo_level, 4'd8);
    check("ovf flag", overflow, 1'b1);
    check("ovf drop_count", drop_count, 8'd2);
    quiet_edge("disabled");

    // Write coincident with launch pop on a full FIFO: no drop
    interrupt_enable = 1'b1;
    irq_clk = 1'b1;
    sample_valid = 1'b1;
    sample_data = 16'hBBBB;
    tick(1);
    irq_clk = 1'b0;
    sample_valid = 1'b0;
    check("fullpop irq", rpi_irq, 1'b1);
    check("fullpop data", rpi_data, 16'hA000);
    check("fullpop level", fifo_level, 4'd8);
    check("fullpop drop_count", drop_count, 8'd2);
    interrupt_enable = 1'b0;  // must not abort the transfer
    handshake("fullpop");
    check("fullpop level after", fifo_level, 4'd8);

`ifdef RPI_IRQ_TIMEOUT_EN
    // Timeout: ack never arrives
    interrupt_enable = 1'b1;
    launch_expect("tmo", 16'hA001, 4'd7);
    tick(255);
    check("tmo irq at cycle 255", rpi_irq, 1'b1);
    tick(1);
    check("tmo irq dropped", rpi_irq, 1'b0);
    check("tmo drop_count", drop_count, 8'd3);
    check("tmo overflow", overflow, 1'b1);
    tick(2);
    launch_expect("tmo next", 16'hA002, 4'd6);
    tick(3);
`else
    interrupt_enable = 1'b1;
    launch_expect("pre-reset", 16'hA001, 4'd7);
    tick(3);
`endif

    // Reset in the middle of PRESENT
    rst_n = 1'b0;
    tick(1);
    check("midrst irq", rpi_irq, 1'b0);
    check("midrst data", rpi_data, 16'h0);
    check("midrst level", fifo_level, 4'd0);
    check("midrst overflow", overflow, 1'b0);
    check("midrst drop_count", drop_count, 8'd0);
    rst_n = 1'b1;
    tick(2);
    quiet_edge("post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
